// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage and IF/ID pipeline register of the WISC-S15 16-bit
// pipeline. Holds the PC, issues word-addressed reads to a multi-cycle
// instruction memory, and hands each accepted instruction plus its PC+1 to
// decode. Supports hazard stalls, downstream redirects and HALT (opcode F).
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   stall               : hold PC and IF/ID (decode hazard)
//   redirect_valid/_pc  : taken branch/call/return, new fetch address
//   imem_addr           : memory word address, always equal to PC
//   imem_rd_en          : read request, high while running and out of reset
//   imem_rdata/_ready   : response word, valid for imem_addr when ready=1
//   if_id_instr         : registered instruction to decode
//   if_id_pc_plus1      : registered address+1 of that instruction
//   if_id_valid         : if_id_instr holds a real instruction
//   halted              : fetch stopped on HALT
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        halted
);

    localparam int unsigned XLEN    = 16;
    localparam int unsigned OP_W    = 4;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus1_q, pc_plus1_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] pc_inc;

    // PC+1 wraps naturally at 16 bits
    assign pc_inc = pc_q + XLEN'(1);

    // Memory request: address tracks PC, request only while running
    assign imem_addr  = pc_q;
    assign imem_rd_en = rst_n & (state_q == ST_RUN);

    assign if_id_instr    = instr_q;
    assign if_id_pc_plus1 = pc_plus1_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            instr_q    <= BUBBLE_INSTR;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state: redirect > stall > response > wait
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;

        unique case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    // Any response this cycle belongs to the wrong path
                    pc_d    = redirect_pc;
                    instr_d = BUBBLE_INSTR;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // Hold everything; the same address is re-requested
                end else if (imem_ready) begin
                    pc_d       = pc_inc;
                    instr_d    = imem_rdata;
                    pc_plus1_d = pc_inc;
                    valid_d    = 1'b1;
                    if (imem_rdata[XLEN-1 -: OP_W] == OP_HALT) begin
                        state_d = ST_HALTED;
                    end
                end else begin
                    instr_d = BUBBLE_INSTR;
                    valid_d = 1'b0;
                end
            end

            ST_HALTED: begin
                if (redirect_valid) begin
                    // HALT was fetched down a mispredicted path
                    state_d = ST_RUN;
                    pc_d    = redirect_pc;
                    instr_d = BUBBLE_INSTR;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = BUBBLE_INSTR;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        halted_d = (state_d == ST_HALTED);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed vector table, hand sequences and randomized traffic for
// fetch_stage, checked against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;

    fetch_stage #(
        .RESET_PC     (16'h0000),
        .BUBBLE_INSTR (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_pc;
    logic        m_halted;
    logic [15:0] m_instr;
    logic [15:0] m_pp1;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 16'h0000; m_halted = 1'b0;
        m_instr = 16'h0000; m_pp1 = 16'h0000; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [15:0] rp,
                              input logic rd, input logic [15:0] w);
        if (r) begin
            m_pc = rp; m_halted = 1'b0; m_instr = 16'h0000; m_valid = 1'b0;
        end else if (s) begin
            // frozen
        end else if (m_halted || !rd) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = w; m_pp1 = m_pc + 16'd1; m_valid = 1'b1;
            m_pc = m_pc + 16'd1;
            if (w[15:12] == 4'hF) m_halted = 1'b1;
        end
    endtask

    // Backing memory contents: deterministic function of address
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] h;
        h = (a * 16'h9E37) ^ 16'h5A5A;
        if (h[15:12] == 4'hF && h[3:0] != 4'h0) h[15:12] = 4'h7;
        return h;
    endfunction

    // One clock of stimulus, checked against the model
    task automatic step(input logic s, input logic r, input logic [15:0] rp,
                        input logic rd, input logic [15:0] w);
        @(negedge clk);
        stall = s; redirect_valid = r; redirect_pc = rp;
        imem_ready = rd; imem_rdata = w;
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("imem_rd_en", 16'(imem_rd_en), 16'(!m_halted));
        model_step(s, r, rp, rd, w);
        @(posedge clk);
        #1;
        check("pc", imem_addr, m_pc);
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc_plus1", if_id_pc_plus1, m_pp1);
        check("if_id_valid", 16'(if_id_valid), 16'(m_valid));
        check("halted", 16'(halted), 16'(m_halted));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, imem_addr, 16'h0000);
        check({tag, "_rd_en"}, 16'(imem_rd_en), 16'h0000);
        check({tag, "_instr"}, if_id_instr, 16'h0000);
        check({tag, "_pp1"}, if_id_pc_plus1, 16'h0000);
        check({tag, "_valid"}, 16'(if_id_valid), 16'h0000);
        check({tag, "_halted"}, 16'(halted), 16'h0000);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        ready;
        logic [15:0] rdata;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_pp1;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    initial begin
        logic [15:0] prev_pc;
        logic        prev_halted;

        //          stall redir rpc      rdy rdata     pc        instr     pp1       v     h
        vec[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0001, 16'h1234, 16'h0001, 1'b1, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2345, 16'h0002, 16'h2345, 16'h0002, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h3456, 16'h0003, 16'h3456, 16'h0003, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hDEAD, 16'h0003, 16'h0000, 16'h0003, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777, 16'h0003, 16'h0000, 16'h0003, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4567, 16'h0004, 16'h4567, 16'h0004, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0004, 16'h4567, 16'h0004, 1'b1, 1'b0};
        vec[7]  = '{1'b1, 1'b1, 16'h0040, 1'b1, 16'h2222, 16'h0040, 16'h0000, 16'h0004, 1'b0, 1'b0};
        vec[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0041, 16'hF000, 16'h0041, 1'b1, 1'b1};
        vec[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'h0041, 16'h0000, 16'h0041, 1'b0, 1'b1};
        vec[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'h0041, 16'h0000, 16'h0041, 1'b0, 1'b1};
        vec[11] = '{1'b0, 1'b1, 16'h0030, 1'b0, 16'h0000, 16'h0030, 16'h0000, 16'h0041, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888, 16'h0031, 16'h8888, 16'h0031, 1'b1, 1'b0};
        vec[13] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h9999, 16'hFFFF, 16'h0000, 16'h0031, 1'b0, 1'b0};
        vec[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1357, 16'h0000, 16'h1357, 16'h0000, 1'b1, 1'b0};
        vec[15] = '{1'b0, 1'b1, 16'h0020, 1'b1, 16'hF123, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vec[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vec[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0021, 16'hF000, 16'h0021, 1'b1, 1'b1};

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        imem_ready = 1'b0; imem_rdata = 16'h0000;
        #3;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        prev_pc = 16'h0000; prev_halted = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            stall = vec[i].stall; redirect_valid = vec[i].redir; redirect_pc = vec[i].rpc;
            imem_ready = vec[i].ready; imem_rdata = vec[i].rdata;
            #1;
            check($sformatf("v%0d_addr_pre", i), imem_addr, prev_pc);
            check($sformatf("v%0d_rd_en", i), 16'(imem_rd_en), 16'(!prev_halted));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i), imem_addr, vec[i].e_pc);
            check($sformatf("v%0d_instr", i), if_id_instr, vec[i].e_instr);
            check($sformatf("v%0d_pp1", i), if_id_pc_plus1, vec[i].e_pp1);
            check($sformatf("v%0d_valid", i), 16'(if_id_valid), 16'(vec[i].e_valid));
            check($sformatf("v%0d_halted", i), 16'(halted), 16'(vec[i].e_halted));
            prev_pc = vec[i].e_pc; prev_halted = vec[i].e_halted;
        end

        // Model now tracks the table's end state
        m_pc = 16'h0021; m_halted = 1'b1; m_instr = 16'hF000; m_pp1 = 16'h0021; m_valid = 1'b1;

        // HALT held in IF/ID under stall, then bubbles, then recovery
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
        step(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000);

        // Three wait cycles at 0x0005, accepted on the fourth
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6006);
        check("wait_accept_pp1", if_id_pc_plus1, 16'h0006);

        // Stall two cycles at 0x0010, then a single acceptance
        step(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'hABCD);
        check("stall_once_pc", imem_addr, 16'h0011);

        // Reset asserted mid-wait: outputs return to reset values at once
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic        s, r, rd;
            logic [15:0] rp, w;
            s  = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = 16'($urandom);
            rd = ($urandom_range(0, 2) != 0);
            w  = rd ? mem_word(m_pc) : 16'($urandom);
            if (rd && $urandom_range(0, 19) == 0) w[15:12] = 4'hF;
            step(s, r, rp, rd, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the WISC-S15 16-bit pipeline.
- Holds the PC and issues word-addressed reads to instruction memory, which can take several cycles.
- Delivers the fetched instruction and PC+1 to the decode stage, where opcode [15:12] drives the control decoder.
- Handles stalls, redirects (branch/call/return targets resolved downstream) and HALT (opcode 4'b1111).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- BUBBLE_INSTR, 16'h0000, instruction word driven into IF/ID when squashed or when no instruction is available.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hazard stall from decode; hold PC and IF/ID
- redirect_valid  input  1  taken branch/call/return this cycle
- redirect_pc  input  16  new fetch address when redirect_valid=1
- imem_addr  output  16  instruction memory word address (= PC)
- imem_rd_en  output  1  read request
- imem_rdata  input  16  instruction word, valid when imem_ready=1
- imem_ready  input  1  imem_rdata valid for the current imem_addr this cycle
- if_id_instr  output  16  registered instruction to decode
- if_id_pc_plus1  output  16  registered PC+1 of that instruction
- if_id_valid  output  1  if_id_instr is a real instruction
- halted  output  1  fetch has stopped on HALT

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - pc=RESET_PC, state=RUN.
  - if_id_instr=BUBBLE_INSTR, if_id_pc_plus1=16'h0000, if_id_valid=0, halted=0.
  - imem_rd_en=0.
  - Reset mid-transaction abandons the access; no state survives.
- Combinational outputs:
  - imem_addr=pc at all times.
  - imem_rd_en=1 only when rst_n=1 and state=RUN.
- Memory protocol:
  - The request is implicitly held while imem_rd_en=1 and imem_addr is stable.
  - When imem_addr changes, the request is aborted.
  - A response arriving while stall=1 is ignored; the same address is re-requested until it is accepted.
- States: RUN, HALTED.
- Per-clock priority in RUN, highest first:
  1. redirect_valid=1: pc<=redirect_pc; if_id_valid<=0; if_id_instr<=BUBBLE_INSTR; imem_rdata this cycle discarded even if imem_ready=1. Overrides stall.
  2. stall=1: pc, if_id_* all hold.
  3. imem_ready=1:
     - if_id_instr<=imem_rdata; if_id_pc_plus1<=pc+1; if_id_valid<=1; pc<=pc+1.
     - Addition is modulo 2^16 (0xFFFF+1=0x0000).
     - If imem_rdata[15:12]==4'b1111, next state=HALTED.
  4. Otherwise (waiting on memory): pc holds; if_id_valid<=0; if_id_instr<=BUBBLE_INSTR.
- Latency:
  - With zero-wait memory (imem_ready=1 every cycle), one instruction enters IF/ID per clock.
  - An instruction is visible on if_id_* the cycle after its accepted response.
- HALTED state:
  - imem_rd_en=0, halted=1, pc holds (points after the HALT word).
  - HALT stays in IF/ID for one cycle (longer if stall=1).
  - Thereafter, when stall=0, IF/ID loads a bubble each clock (if_id_valid=0).
  - redirect_valid=1 means the HALT was on a wrong path: pc<=redirect_pc, IF/ID bubble, state<=RUN, halted<=0 next cycle.
  - Only redirect or reset leaves HALTED.
- Simultaneous events:
  - A redirect in the same cycle a HALT response arrives: the HALT is discarded and the state stays RUN.
  - stall together with a HALT response: the response is ignored and no state change occurs.
- if_id_pc_plus1 always equals the accepted instruction's address+1; it is the return address used by CALL.

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1, memory returns 0x1234,0x2345,0x3456 → imem_addr 0,1,2 on consecutive clocks; if_id_instr 0x1234 with pc_plus1=1 on the cycle after the first accept; valid=1 thereafter.
- imem_ready held low 3 cycles at addr 0x0005 → imem_addr stays 0x0005, if_id_valid=0 and if_id_instr=BUBBLE_INSTR for those cycles; the 4th-cycle response is accepted with pc_plus1=0x0006.
- stall=1 for 2 cycles with imem_ready=1 at pc=0x0010 → pc and if_id_* frozen; after release, the word at 0x0010 is accepted exactly once.
- redirect_valid=1, redirect_pc=0x0040, simultaneous with stall=1 and imem_ready=1 → next cycle pc=0x0040, if_id_valid=0, response discarded.
- Fetch 0xF000 at 0x0020 → halted=1 the next cycle, imem_rd_en=0, pc=0x0021, bubbles follow; a later redirect to 0x0030 → halted=0, fetch resumes at 0x0030.
- pc=0xFFFF with ready → pc wraps to 0x0000, if_id_pc_plus1=0x0000; assert rst_n=0 mid-wait → all outputs return to reset values immediately.
